// File: rtl/tetris_field_render.sv
// Tetris playfield renderer: cell colour storage, clear sweep FSM and 2-stage pixel pipeline.
// Optional macro GRID_LINES_EN draws dim grey cell borders on empty cells.
module tetris_field_render #(
  parameter int FIELD_X0 = 220,
  parameter int FIELD_Y0 = 20,
  parameter int CELL     = 10,
  parameter int COLS     = 20,
  parameter int ROWS     = 44
) (
  input  logic       VGA_CTRL_CLK,
  input  logic       RST,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       wr_en,
  input  logic [4:0] wr_col,
  input  logic [5:0] wr_row,
  input  logic [2:0] wr_color,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  localparam int          LSB_W    = $clog2(COLS * 3);
  localparam logic [10:0] X_LO     = 11'(FIELD_X0);
  localparam logic [10:0] X_HI     = 11'(FIELD_X0 + COLS * CELL);
  localparam logic [10:0] Y_LO     = 11'(FIELD_Y0);
  localparam logic [10:0] Y_HI     = 11'(FIELD_Y0 + ROWS * CELL);
  localparam logic [9:0]  X0       = 10'(FIELD_X0);
  localparam logic [9:0]  Y0       = 10'(FIELD_Y0);
  localparam logic [9:0]  CELL_W   = 10'(CELL);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

  function automatic logic [11:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    palette = 12'h0FF;
      3'd2:    palette = 12'h00F;
      3'd3:    palette = 12'hF80;
      3'd4:    palette = 12'hFF0;
      3'd5:    palette = 12'h0F0;
      3'd6:    palette = 12'h80F;
      3'd7:    palette = 12'hF00;
      default: palette = 12'h000;
    endcase
  endfunction

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_nxt;
  logic [5:0] clr_row, clr_row_nxt;
  logic       wr_ok, clr_now;

  always_comb begin
    state_nxt   = state;
    clr_row_nxt = clr_row;
    wr_ok       = 1'b0;
    clr_now     = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_row_nxt = '0;
        end else if (wr_en && (int'(wr_col) < COLS) && (int'(wr_row) < ROWS)) begin
          wr_ok = 1'b1;
        end
      end
      CLEAR: begin
        clr_now = 1'b1;
        if (clr_row == LAST_ROW) begin
          state_nxt   = IDLE;
          clr_row_nxt = '0;
        end else begin
          clr_row_nxt = clr_row + 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      clr_row <= '0;
    end else begin
      state   <= state_nxt;
      clr_row <= clr_row_nxt;
    end
  end

  assign clr_busy = (state == CLEAR);

  logic [COLS*3-1:0] cells [ROWS];
  logic [LSB_W-1:0]  wr_lsb;

  assign wr_lsb = LSB_W'(3 * wr_col);

  // A clear row and a cell write never coincide: writes are only accepted in IDLE.
  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < ROWS; i++) cells[i] <= '0;
    end else if (clr_now) begin
      cells[clr_row] <= '0;
    end else if (wr_ok) begin
      cells[wr_row][wr_lsb +: 3] <= wr_color;
    end
  end

  logic [9:0] dx, dy;
  logic       in_range;

  assign dx       = px - X0;
  assign dy       = py - Y0;
  assign in_range = ({1'b0, px} >= X_LO) && ({1'b0, px} < X_HI) &&
                    ({1'b0, py} >= Y_LO) && ({1'b0, py} < Y_HI);

  // Stage 1: field test and cell coordinates (zeroed outside the field so reads stay in range)
  logic       in_field_p0;
  logic [4:0] col_p0;
  logic [5:0] row_p0;
`ifdef GRID_LINES_EN
  logic       grid_p0;
`endif

  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST) begin
      in_field_p0 <= 1'b0;
      col_p0      <= '0;
      row_p0      <= '0;
`ifdef GRID_LINES_EN
      grid_p0     <= 1'b0;
`endif
    end else begin
      in_field_p0 <= in_range;
      col_p0      <= in_range ? 5'(dx / CELL_W) : 5'd0;
      row_p0      <= in_range ? 6'(dy / CELL_W) : 6'd0;
`ifdef GRID_LINES_EN
      grid_p0     <= ((dx % CELL_W) == 10'd0) || ((dy % CELL_W) == 10'd0);
`endif
    end
  end

  // Stage 2: cell lookup and palette
  logic [LSB_W-1:0] rd_lsb;
  logic [2:0]       cell_idx;
  logic [11:0]      rgb_nxt, rgb_p1;

  assign rd_lsb   = LSB_W'(3 * col_p0);
  assign cell_idx = cells[row_p0][rd_lsb +: 3];

  always_comb begin
    rgb_nxt = 12'h000;
    if (in_field_p0) begin
      rgb_nxt = palette(cell_idx);
`ifdef GRID_LINES_EN
      if ((cell_idx == 3'd0) && grid_p0) rgb_nxt = 12'h333;
`endif
    end
  end

  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST) rgb_p1 <= '0;
    else      rgb_p1 <= rgb_nxt;
  end

  assign r = rgb_p1[11:8];
  assign g = rgb_p1[7:4];
  assign b = rgb_p1[3:0];

endmodule

// File: tb/tb_tetris_field_render.sv
// Self-checking bench for tetris_field_render: directed vectors, clear sequences and
// randomized pixel streams compared against a cell-array reference model.
module tb_tetris_field_render;

  logic       VGA_CTRL_CLK = 1'b0;
  logic       RST = 1'b0;
  logic [9:0] px = '0, py = '0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_col = '0;
  logic [5:0] wr_row = '0;
  logic [2:0] wr_color = '0;
  logic       clr_req = 1'b0;
  logic       clr_busy;
  logic [3:0] r, g, b;

  tetris_field_render dut (
    .VGA_CTRL_CLK(VGA_CTRL_CLK), .RST(RST), .px(px), .py(py),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_color(wr_color),
    .clr_req(clr_req), .clr_busy(clr_busy), .r(r), .g(g), .b(b)
  );

  always #5 VGA_CTRL_CLK = ~VGA_CTRL_CLK;

  int tests = 0;
  int fails = 0;
  int model [44][20];
  int pal [8] = '{'h000, 'h0FF, 'h00F, 'hF80, 'hFF0, 'h0F0, 'h80F, 'hF00};

  typedef struct {
    int    x;
    int    y;
    int    exp;
    string nm;
  } vec_t;
  vec_t vecs [8];

  function automatic int rgb();
    return int'({r, g, b});
  endfunction

  function automatic int exp_rgb(input int x, input int y);
    int idx;
    if (x < 220 || x >= 420 || y < 20 || y >= 460) return 0;
    idx = model[(y - 20) / 10][(x - 220) / 10];
`ifdef GRID_LINES_EN
    if (idx == 0 && (((x - 220) % 10) == 0 || ((y - 20) % 10) == 0)) return 'h333;
`endif
    return pal[idx];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    foreach (model[i, j]) model[i][j] = 0;
  endtask

  task automatic do_write(input int c, input int rw, input int col);
    @(negedge VGA_CTRL_CLK);
    wr_en = 1'b1; wr_col = 5'(c); wr_row = 6'(rw); wr_color = 3'(col);
    @(negedge VGA_CTRL_CLK);
    wr_en = 1'b0;
    if (c < 20 && rw < 44) model[rw][c] = col;
  endtask

  task automatic check_px(input int x, input int y, input int exp, input string nm);
    @(negedge VGA_CTRL_CLK);
    px = 10'(x); py = 10'(y);
    @(negedge VGA_CTRL_CLK);
    @(negedge VGA_CTRL_CLK);
    chk(nm, rgb(), exp);
  endtask

  // mode 0: random pixels; mode 1: centre of every cell in raster order
  task automatic stream(input int n, input int mode, input string nm);
    int q [$];
    int x, y;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge VGA_CTRL_CLK);
      if (i >= 2) chk(nm, rgb(), q.pop_front());
      if (i < n) begin
        if (mode == 1) begin
          x = 225 + (i % 20) * 10;
          y = 25 + (i / 20) * 10;
        end else if ($urandom_range(0, 7) == 0) begin
          x = $urandom_range(0, 1023);
          y = $urandom_range(0, 1023);
        end else begin
          x = $urandom_range(210, 430);
          y = $urandom_range(10, 470);
        end
        px = 10'(x); py = 10'(y);
        q.push_back(exp_rgb(x, y));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit done;
    vecs[0] = '{225, 25, 'h0FF, "c00_center"};
    vecs[1] = '{219, 25, 'h000, "left_out"};
    vecs[2] = '{220, 20, 'h0FF, "c00_corner"};
    vecs[3] = '{229, 29, 'h0FF, "c00_far"};
    vecs[4] = '{419, 459, 'hF00, "c19_43"};
    vecs[5] = '{420, 459, 'h000, "right_out"};
    vecs[6] = '{419, 460, 'h000, "bottom_out"};
    vecs[7] = '{225, 19, 'h000, "top_out"};
    model_clear();

    px = 10'd225; py = 10'd25;
    repeat (3) @(negedge VGA_CTRL_CLK);
    chk("reset_rgb", rgb(), 0);
    chk("reset_busy", int'(clr_busy), 0);
    RST = 1'b1;
    check_px(225, 25, 0, "empty_after_reset");

    do_write(0, 0, 1);
    do_write(19, 43, 7);
    foreach (vecs[i]) check_px(vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].nm);

    do_write(20, 5, 3);
    do_write(3, 44, 2);
    do_write(31, 63, 4);
    for (int c = 0; c < 20; c++) check_px(225 + c * 10, 75, exp_rgb(225 + c * 10, 75), "row5_black");
    chk("row5_model", exp_rgb(225, 75), 0);

    for (int i = 0; i < 60; i++)
      do_write($urandom_range(0, 21), $urandom_range(0, 45), $urandom_range(0, 7));
    stream(400, 0, "rand_stream");

    do_write(0, 40, 6);
    do_write(0, 0, 1);
    do_write(2, 2, 0);

    // Clear with a simultaneous write, probing rendering mid-sweep
    @(negedge VGA_CTRL_CLK);
    clr_req = 1'b1; wr_en = 1'b1; wr_col = 5'd2; wr_row = 6'd2; wr_color = 3'd5;
    @(negedge VGA_CTRL_CLK);
    clr_req = 1'b0; wr_en = 1'b0;
    cnt = 0;
    while (clr_busy == 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 1) begin px = 10'd225; py = 10'd425; end
      if (cnt == 3) begin
        chk("clear_uncleared_row40", rgb(), 'h80F);
        px = 10'd225; py = 10'd25;
      end
      if (cnt == 5) chk("clear_cleared_row0", rgb(), 0);
      @(negedge VGA_CTRL_CLK);
    end
    chk("clear_busy_cycles", cnt, 44);
    model_clear();
    stream(880, 1, "board_empty_1");

`ifdef GRID_LINES_EN
    check_px(230, 25, 'h333, "grid_line");
    check_px(231, 25, 'h000, "grid_inner");
`endif

    // Second clear: re-request mid-sweep, then reset during the sweep
    do_write(0, 15, 2);
    do_write(0, 40, 6);
    do_write(7, 30, 3);
    px = 10'd225; py = 10'd175;
    @(negedge VGA_CTRL_CLK);
    clr_req = 1'b1;
    @(negedge VGA_CTRL_CLK);
    clr_req = 1'b0;
    cnt = 0;
    done = 1'b0;
    while (!done && clr_busy == 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 10) clr_req = 1'b1;
      if (cnt == 11) clr_req = 1'b0;
      if (cnt == 18) begin
        chk("no_restart_row15", rgb(), 0);
        px = 10'd225; py = 10'd425;
      end
      if (cnt == 20) begin
        chk("pre_reset_row40", rgb(), 'h80F);
        RST = 1'b0;
        #1;
        chk("reset_busy_async", int'(clr_busy), 0);
        chk("reset_rgb_async", rgb(), 0);
        done = 1'b1;
      end
      if (!done) @(negedge VGA_CTRL_CLK);
    end
    chk("reset_reached_cycle20", cnt, 20);
    @(negedge VGA_CTRL_CLK);
    RST = 1'b1;
    model_clear();
    stream(880, 1, "board_empty_2");
    check_px(225, 425, 0, "row40_empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
